chip8_program_loader: RTL

- Sequential copy engine. It reads the CHIP-8 program image out of the combinational program ROM and writes it byte-by-byte into the CHIP-8 main RAM at the same addresses (LOAD_BASE upward).
- It can optionally zero the interpreter area below LOAD_BASE first.
- It sits between the program ROM and the RAM write port. The CPU is held off while `busy` is high and starts fetching at 0x200 once `done` is high.

---
 rtl/chip8_program_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/chip8_program_loader.sv
// Copies the CHIP-8 program image from the combinational ROM into main RAM.
// Can optionally zero the interpreter area below LOAD_BASE first.
//
// state  | meaning
// IDLE   | waiting for start; done holds the result of the last load
// CLEAR  | writing 8'h00 to RAM 0x000..LOAD_BASE-1
// COPY   | one ROM byte per non-held cycle copied to RAM, checksum accumulated
// FINISH | last strobe issued; drop busy, raise done
module chip8_program_loader #(
    parameter logic [11:0] LOAD_BASE     = 12'h200,
    parameter int          LOAD_LENGTH   = 256,
    parameter bit          CLEAR_LOW_RAM = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    output logic [11:0] rom_read_address,
    input  logic [7:0]  rom_data,
    output logic        ram_write_enable,
    output logic [11:0] ram_write_address,
    output logic [7:0]  ram_write_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum
);

    typedef enum logic [1:0] {IDLE, CLEAR, COPY, FINISH} state_t;

    localparam bit          DO_CLEAR   = CLEAR_LOW_RAM && (LOAD_BASE != 12'd0);
    localparam logic [12:0] CLEAR_LAST = {1'b0, LOAD_BASE} - 13'd1;
    localparam logic [12:0] COPY_LAST  = 13'(LOAD_LENGTH - 1);

    state_t      state, state_nx;
    logic [12:0] count, count_nx;
    logic [11:0] rom_addr_nx, wr_addr_nx;
    logic [7:0]  wr_data_nx;
    logic        wr_en_nx, busy_nx, done_nx;
    logic [15:0] sum_nx;

    always_comb begin
        state_nx    = state;
        count_nx    = count;
        rom_addr_nx = rom_read_address;
        wr_en_nx    = 1'b0;
        wr_addr_nx  = ram_write_address;
        wr_data_nx  = ram_write_data;
        busy_nx     = busy;
        done_nx     = done;
        sum_nx      = checksum;
        case (state)
            IDLE: begin
                if (start) begin
                    busy_nx     = 1'b1;
                    done_nx     = 1'b0;
                    sum_nx      = 16'd0;
                    rom_addr_nx = LOAD_BASE;
                    count_nx    = 13'd0;
                    state_nx    = DO_CLEAR ? CLEAR : COPY;
                end
            end
            CLEAR: begin
                if (!hold) begin
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = count[11:0];
                    wr_data_nx = 8'h00;
                    count_nx   = count + 13'd1;
                    if (count == CLEAR_LAST) begin
                        state_nx = COPY;
                        count_nx = 13'd0;
                    end
                end
            end
            COPY: begin
                // ROM is combinational, so the byte for rom_read_address is written this edge
                if (!hold) begin
                    wr_en_nx    = 1'b1;
                    wr_addr_nx  = rom_read_address;
                    wr_data_nx  = rom_data;
                    sum_nx      = checksum + {8'h00, rom_data};
                    rom_addr_nx = rom_read_address + 12'd1;
                    count_nx    = count + 13'd1;
                    if (count == COPY_LAST) state_nx = FINISH;
                end
            end
            FINISH: begin
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            count             <= 13'd0;
            rom_read_address  <= LOAD_BASE;
            ram_write_enable  <= 1'b0;
            ram_write_address <= 12'd0;
            ram_write_data    <= 8'h00;
            busy              <= 1'b0;
            done              <= 1'b0;
            checksum          <= 16'd0;
        end else begin
            state             <= state_nx;
            count             <= count_nx;
            rom_read_address  <= rom_addr_nx;
            ram_write_enable  <= wr_en_nx;
            ram_write_address <= wr_addr_nx;
            ram_write_data    <= wr_data_nx;
            busy              <= busy_nx;
            done              <= done_nx;
            checksum          <= sum_nx;
        end
    end

endmodule
